// File: rtl/dac_distance_controller.sv
// -----------------------------------------------------------------------------
// dac_distance_controller
//
// Automatic bit-window controller for the TX DAC truncation stage. It measures
// the per-window peak of significant bits in the signed sample stream. From that
// peak it drives the truncator's 8-bit distance select. Rises are applied at
// once. Falls are applied one step at a time, and only after HOLD_WINDOWS
// consecutive low windows.
//
// Optional feature macro: DAC_CLIP_COUNTER_EN
//   When defined, this adds a saturating 16-bit clip counter with a
//   synchronous clear.
//
// Ports
//   clk_in           in   1   sample clock
//   rst_in           in   1   asynchronous, active-high reset
//   data_valid_in    in   1   qualifies DATA_IN
//   DATA_IN          in   IN_WIDTH  signed two's-complement sample
//   auto_en          in   1   1 = automatic control, 0 = manual
//   manual_distance  in   8   distance used while auto_en = 0
//   clip_count_clr   in   1   (DAC_CLIP_COUNTER_EN only) zero clip_count
//   clip_count       out  16  (DAC_CLIP_COUNTER_EN only) saturating clip count
//   distance_out     out  8   select driven to the truncator
//   update_strobe    out  1   one-cycle pulse whenever distance_out changes
//   clip_flag        out  1   one-cycle pulse per clipped sample
//   peak_bits_out    out  6   significant-bit peak of the last applied window
//
// Latency: clip_flag appears 2 cycles after its sample. distance_out,
// update_strobe and peak_bits_out appear 4 cycles after the window-closing
// sample (S1, S2, eval, apply).
// -----------------------------------------------------------------------------
module dac_distance_controller #(
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 14,
    parameter int WINDOW_LOG2  = 10,
    parameter int HOLD_WINDOWS = 4,
    parameter int HEADROOM     = 1,
    parameter int MIN_DISTANCE = 14,
    parameter int MAX_DISTANCE = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                data_valid_in,
    input  logic [IN_WIDTH-1:0] DATA_IN,
    input  logic                auto_en,
    input  logic [7:0]          manual_distance,
`ifdef DAC_CLIP_COUNTER_EN
    input  logic                clip_count_clr,
    output logic [15:0]         clip_count,
`endif
    output logic [7:0]          distance_out,
    output logic                update_strobe,
    output logic                clip_flag,
    output logic [5:0]          peak_bits_out
);

    // A select below the slice width would address bits under the sample LSB.
    // For that reason the lower clamp never drops below OUT_WIDTH.
    localparam int DIST_LO = (MIN_DISTANCE > OUT_WIDTH) ? MIN_DISTANCE : OUT_WIDTH;

    // The hold counter only needs to count up to HOLD_WINDOWS-1.
    // Reaching that value and seeing one more low window triggers the decay step.
    localparam int HOLD_W = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WINDOWS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    localparam logic [WINDOW_LOG2-1:0] CNT_LAST = {WINDOW_LOG2{1'b1}};
    localparam logic [WINDOW_LOG2-1:0] CNT_ONE  = WINDOW_LOG2'(1);
    localparam logic [WINDOW_LOG2-1:0] CNT_ZERO = WINDOW_LOG2'(0);

    // EVAL and APPLY each last one cycle. They overlap accumulation of the next
    // window, so a window must hold at least 4 samples for closes not to collide.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EVAL  = 2'd2,
        ST_APPLY = 2'd3
    } state_e;

    // Significant bits of a signed value: the position of the top set bit of x,
    // or of ~x for negatives, plus one. x then fits signed in that many bits + 1.
    function automatic logic [5:0] sig_bits(input logic [IN_WIDTH-1:0] x);
        logic [IN_WIDTH-1:0] mag;
        logic [5:0]          n;
        mag = x[IN_WIDTH-1] ? ~x : x;
        n   = 6'd0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (mag[i]) begin
                n = 6'(i + 1);
            end
        end
        return n;
    endfunction

    // Limit a candidate distance to the legal select range.
    function automatic logic [7:0] clamp_dist(input logic [8:0] v);
        logic [7:0] r;
        if (v < 9'(DIST_LO)) begin
            r = 8'(DIST_LO);
        end else if (v > 9'(MAX_DISTANCE)) begin
            r = 8'(MAX_DISTANCE);
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    // Pipeline stage 1
    logic [5:0]             nb_d;
    logic [5:0]             nb_q;
    logic                   v1_q;

    // Window accumulator (stage 2)
    logic [WINDOW_LOG2-1:0] win_cnt_q;
    logic [5:0]             win_max_q;
    logic [5:0]             win_max_d;
    logic [5:0]             eval_peak_q;
    logic                   win_close_s;
    logic                   accum_en_s;

    // Control
    state_e                 state_q;
    logic [7:0]             target_d;
    logic [7:0]             target_q;
    logic [7:0]             manual_d;
    logic [HOLD_W-1:0]      hold_q;
    logic [7:0]             distance_q;
    logic                   update_strobe_q;
    logic [5:0]             peak_bits_q;
    logic                   clip_flag_q;

    // Significant-bit count of the incoming sample.
    always_comb begin
        nb_d = sig_bits(DATA_IN);
    end

    // Window bookkeeping: the running max including the S2 sample, and close detection.
    always_comb begin
        win_max_d   = (nb_q > win_max_q) ? nb_q : win_max_q;
        win_close_s = v1_q && (win_cnt_q == CNT_LAST);
        accum_en_s  = auto_en && (state_q != ST_IDLE);
    end

    // Target for the closed window and the clamped manual request.
    always_comb begin
        target_d = clamp_dist({3'b000, eval_peak_q} + 9'(1 + HEADROOM));
        manual_d = clamp_dist({1'b0, manual_distance});
    end

    // Stage 1: register the significant-bit count and its valid.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            nb_q <= 6'd0;
            v1_q <= 1'b0;
        end else begin
            nb_q <= nb_d;
            v1_q <= data_valid_in;
        end
    end

    // Stage 2: window max and sample counter.
    // On close, the max is handed to eval and the accumulator restarts.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            win_cnt_q   <= CNT_ZERO;
            win_max_q   <= 6'd0;
            eval_peak_q <= 6'd0;
        end else if (!accum_en_s) begin
            // Manual mode, or the first cycle after enabling: the window starts empty.
            win_cnt_q <= CNT_ZERO;
            win_max_q <= 6'd0;
        end else if (v1_q) begin
            if (win_close_s) begin
                eval_peak_q <= win_max_d;
                win_cnt_q   <= CNT_ZERO;
                win_max_q   <= 6'd0;
            end else begin
                win_max_q <= win_max_d;
                win_cnt_q <= win_cnt_q + CNT_ONE;
            end
        end
    end

    // Stage 2: clip detection against the distance currently in force.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clip_flag_q <= 1'b0;
        end else begin
            clip_flag_q <= v1_q && ({2'b00, nb_q} >= distance_q);
        end
    end

    // Control FSM. It handles manual tracking, eval of a closed window, and the
    // attack/hold/decay apply step.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= ST_IDLE;
            target_q        <= 8'd0;
            hold_q          <= HOLD_ZERO;
            distance_q      <= 8'(MAX_DISTANCE);
            update_strobe_q <= 1'b0;
            peak_bits_q     <= 6'd0;
        end else begin
            update_strobe_q <= 1'b0;
            if (!auto_en) begin
                // Dropping auto_en discards any window or update still in flight.
                state_q         <= ST_IDLE;
                hold_q          <= HOLD_ZERO;
                distance_q      <= manual_d;
                update_strobe_q <= (manual_d != distance_q);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // The fresh window starts next cycle.
                        // distance_out keeps its last manual value.
                        state_q <= ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        if (win_close_s) begin
                            state_q <= ST_EVAL;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                    ST_EVAL: begin
                        target_q <= target_d;
                        state_q  <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        state_q     <= ST_ACCUM;
                        peak_bits_q <= eval_peak_q;
                        if (target_q > distance_q) begin
                            // Fast attack.
                            distance_q      <= target_q;
                            update_strobe_q <= 1'b1;
                            hold_q          <= HOLD_ZERO;
                        end else if (target_q < distance_q) begin
                            // Slow decay. Target is never below the clamp floor,
                            // so a single-step decrement cannot leave the legal range.
                            if (hold_q == HOLD_LAST) begin
                                distance_q      <= distance_q - 8'd1;
                                update_strobe_q <= 1'b1;
                                hold_q          <= HOLD_ZERO;
                            end else begin
                                hold_q <= hold_q + HOLD_ONE;
                            end
                        end else begin
                            hold_q <= HOLD_ZERO;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DAC_CLIP_COUNTER_EN
    logic [15:0] clip_count_q;

    // Saturating clip-pulse counter. A clear wins over a simultaneous clip.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clip_count_q <= 16'd0;
        end else if (clip_count_clr) begin
            clip_count_q <= 16'd0;
        end else if (clip_flag_q && (clip_count_q != 16'hFFFF)) begin
            clip_count_q <= clip_count_q + 16'd1;
        end
    end

    assign clip_count = clip_count_q;
`endif

    assign distance_out  = distance_q;
    assign update_strobe = update_strobe_q;
    assign clip_flag     = clip_flag_q;
    assign peak_bits_out = peak_bits_q;

endmodule
